// File: rtl/alu_share_arb_pkg.sv
// alu_arb_pkg: shared state encoding and ALUFN codes for the shared-ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  localparam logic [5:0] ADD   = 6'h00;
  localparam logic [5:0] SUB   = 6'h01;
  localparam logic [5:0] MUL   = 6'h02;
  localparam logic [5:0] AND   = 6'h18;
  localparam logic [5:0] OR    = 6'h1E;
  localparam logic [5:0] XOR   = 6'h16;
  localparam logic [5:0] A     = 6'h1A;
  localparam logic [5:0] SHL   = 6'h20;
  localparam logic [5:0] SRA   = 6'h23;
  localparam logic [5:0] CMPEQ = 6'h33;
  localparam logic [5:0] CMPLT = 6'h35;
  localparam logic [5:0] CMPLE = 6'h37;
endpackage

// File: rtl/alu_share_arb_alu.sv
// Alu: combinational ALU decoding the ALUFN map; flags come from the add/sub unit
module Alu
  import alu_arb_pkg::*;
(
  input  logic [5:0]  alufn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] alu,
  output logic        z,
  output logic        v,
  output logic        n
);
  logic [31:0] bb;
  logic [31:0] s;
  logic        lt;
  // alufn[0] selects subtract, which also serves the compares
  always_comb begin
    bb = alufn[0] ? ~b : b;
    s = a + bb + {31'b0, alufn[0]};
    z = s == '0;
    n = s[31];
    v = (a[31] == bb[31]) && (s[31] != a[31]);
    lt = n ^ v;
    alu = '0;
    case (alufn)
      ADD, SUB: alu = s;
      MUL:      alu = a * b;
      AND:      alu = a & b;
      OR:       alu = a | b;
      XOR:      alu = a ^ b;
      A:        alu = a;
      SHL:      alu = a << b[4:0];
      SRA:      alu = $signed(a) >>> b[4:0];
      CMPEQ:    alu = {31'b0, z};
      CMPLT:    alu = {31'b0, lt};
      CMPLE:    alu = {31'b0, z | lt};
      default:  alu = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// rr_pick: round-robin winner selection starting at ptr, scanning upward with wrap
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] j;
  // scan farthest-first so the candidate closest to ptr overwrites the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt = NREQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one registered ALU among NREQ requesters
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [6*NREQ-1:0] req_alufn,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_z,
  output logic              rsp_v,
  output logic              rsp_n,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id
);
  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  nxt_ptr;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic [5:0]      op_fn;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [31:0]     alu_y;
  logic            alu_z;
  logic            alu_v;
  logic            alu_n;

  assign done = state == RESP && rsp_ready[owner];
  assign nxt_ptr = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign cand = (state == IDLE || done) ? req_valid : '0;
  assign req_ready = gnt;
  assign gnt_id = owner;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (cand),
    .ptr (done ? nxt_ptr : ptr),
    .gnt (gnt),
    .idx (win)
  );

  Alu u_alu (
    .alufn (op_fn),
    .a     (op_a),
    .b     (op_b),
    .alu   (alu_y),
    .z     (alu_z),
    .v     (alu_v),
    .n     (alu_n)
  );

  // FSM; an accept in the completing RESP cycle overrides the fall back to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      busy <= 1'b0;
      rsp_valid <= '0;
      op_fn <= '0;
      op_a <= '0;
      op_b <= '0;
      rsp_data <= '0;
      rsp_z <= 1'b0;
      rsp_v <= 1'b0;
      rsp_n <= 1'b0;
    end else begin
      if (state == EXEC) begin
        rsp_data <= alu_y;
        rsp_z <= alu_z;
        rsp_v <= alu_v;
        rsp_n <= alu_n;
        rsp_valid <= NREQ'(1) << owner;
        state <= RESP;
      end
      if (done) begin
        ptr <= nxt_ptr;
        rsp_valid <= '0;
        busy <= 1'b0;
        state <= IDLE;
      end
      if (|gnt) begin
        op_fn <= req_alufn[6*win +: 6];
        op_a <= req_a[32*win +: 32];
        op_b <= req_b[32*win +: 32];
        owner <= win;
        busy <= 1'b1;
        state <= EXEC;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random checks of alu_share_arb against a transaction model
module tb_alu_share_arb;
  import alu_arb_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [17:0] req_alufn;
  logic [95:0] req_a, req_b;
  logic [31:0] rsp_data;
  logic        rsp_z, rsp_v, rsp_n, busy;
  logic [1:0]  gnt_id;

  int total = 0, bad = 0, cnt = 0;
  bit inflight, pf, hf, pz, pv, pn, hz, hv, hn;
  int own, age, last;
  logic [31:0] pr, held;
  int acc_id[$], acc_cyc[$];
  logic [5:0] ops [13] = '{ADD, SUB, MUL, AND, OR, XOR, A, SHL, SRA, CMPEQ, CMPLT, CMPLE, 6'h3F};

  alu_share_arb #(.NREQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_alufn(req_alufn), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_v(rsp_v),
    .rsp_n(rsp_n), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      ADD:   return a + b;
      SUB:   return a - b;
      MUL:   return a * b;
      AND:   return a & b;
      OR:    return a | b;
      XOR:   return a ^ b;
      A:     return a;
      SHL:   return a << b[4:0];
      SRA:   return $signed(a) >>> b[4:0];
      CMPEQ: return {31'b0, a == b};
      CMPLT: return {31'b0, $signed(a) < $signed(b)};
      CMPLE: return {31'b0, $signed(a) <= $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    inflight = 0;
    last = 2;
    held = 0;
    {hz, hv, hn} = 3'b000;
    hf = 1;
  endtask

  task automatic set_op(int i, logic [5:0] f, logic [31:0] a, logic [31:0] b);
    req_alufn[6*i +: 6] = f;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 3; i++)
      set_op(i, ops[$urandom_range(0, 12)],
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom));
  endtask

  // one clock: check outputs at negedge against the model, then advance the model at posedge
  task automatic cyc();
    bit resp_now, done;
    int start, w;
    logic [2:0] er;
    longint s;
    logic [5:0] f;
    logic [31:0] a, b;
    @(negedge clk);
    resp_now = inflight && age >= 1;
    done = resp_now && rsp_ready[own];
    start = ((done ? own : last) + 1) % 3;
    w = -1;
    if (!inflight || done)
      for (int k = 0; k < 3; k++)
        if (w < 0 && req_valid[(start + k) % 3]) w = (start + k) % 3;
    er = (w >= 0) ? 3'(1 << w) : 3'b000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), resp_now ? 32'(1 << own) : 32'h0);
    chk("busy", 32'(busy), 32'(inflight));
    if (inflight) chk("gnt_id", 32'(gnt_id), 32'(own));
    chk("rsp_data", rsp_data, held);
    if (hf) chk("flags", {29'b0, rsp_z, rsp_v, rsp_n}, {29'b0, hz, hv, hn});
    for (int k = 0; k < 3; k++)
      if (req_ready[k]) begin
        acc_id.push_back(k);
        acc_cyc.push_back(cnt);
      end
    @(posedge clk);
    cnt++;
    if (!rst_n) model_reset();
    else begin
      if (inflight) begin
        age++;
        if (age == 1) begin
          held = pr;
          {hz, hv, hn} = {pz, pv, pn};
          hf = pf;
        end
      end
      if (done) begin
        inflight = 0;
        last = own;
      end
      if (w >= 0) begin
        f = req_alufn[6*w +: 6];
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        inflight = 1;
        own = w;
        age = 0;
        pr = ref_alu(f, a, b);
        s = (f == SUB) ? longint'($signed(a)) - longint'($signed(b))
                       : longint'($signed(a)) + longint'($signed(b));
        pz = s[31:0] == 32'h0;
        pn = s[31];
        pv = s != longint'($signed(s[31:0]));
        pf = (f == ADD || f == SUB);
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    req_valid = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    req_valid = 0;
    rsp_ready = 3'b111;
    req_alufn = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    // single ADD
    set_op(0, ADD, 5, 3);
    req_valid = 3'b001;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("add_data", rsp_data, 32'd8);
    chk("add_z", 32'(rsp_z), 32'h0);
    // simultaneous requests, starting from ptr 0
    pulse_reset();
    set_op(0, SUB, 3, 3);
    set_op(1, AND, 32'hF0F0, 32'hFF00);
    req_valid = 3'b011;
    cyc();
    req_valid = 3'b010;
    repeat (2) cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("and_data", rsp_data, 32'hF000);
    // back-pressure on requester 0 while requester 1 waits
    set_op(0, XOR, 32'h1234, 32'h00FF);
    set_op(1, OR, 32'h0F00, 32'h00F0);
    rsp_ready = 3'b000;
    req_valid = 3'b001;
    cyc();
    req_valid = 3'b010;
    repeat (6) cyc();
    rsp_ready = 3'b111;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("bp_data", rsp_data, 32'h0FF0);
    // fairness with all requesters valid
    pulse_reset();
    acc_id.delete();
    acc_cyc.delete();
    req_valid = 3'b111;
    repeat (13) begin
      rand_ops();
      cyc();
    end
    req_valid = 0;
    repeat (3) cyc();
    chk("fair_cnt", 32'(acc_id.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < acc_id.size(); i++) begin
      chk("fair_id", 32'(acc_id[i]), 32'(i % 3));
      if (i > 0) chk("fair_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end
    // signed compares
    set_op(2, CMPLT, 32'hFFFFFFFF, 1);
    req_valid = 3'b100;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("cmplt", rsp_data, 32'd1);
    set_op(2, CMPLE, 7, 7);
    req_valid = 3'b100;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("cmple", rsp_data, 32'd1);
    set_op(2, CMPEQ, 7, 8);
    req_valid = 3'b100;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("cmpeq", rsp_data, 32'd0);
    // reset while the operation is in EXEC
    set_op(0, MUL, 6, 7);
    req_valid = 3'b001;
    cyc();
    req_valid = 0;
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("rx_busy", 32'(busy), 32'h0);
    chk("rx_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rx_data", rsp_data, 32'h0);
    chk("rx_gnt_id", 32'(gnt_id), 32'h0);
    chk("rx_flags", {29'b0, rsp_z, rsp_v, rsp_n}, 32'h0);
    repeat (3) cyc();
    set_op(1, SHL, 1, 4);
    req_valid = 3'b010;
    cyc();
    req_valid = 0;
    repeat (3) cyc();
    chk("rx_next", rsp_data, 32'd16);
    // random traffic with occasional resets
    repeat (400) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req_valid = 3'($urandom);
      rsp_ready = 3'($urandom | $urandom);
      rand_ops();
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
